mbist_controller: RTL
=====================

// Module: mbist_controller
// PURPOSE
//  March C- MBIST engine for single-port memory behind the memory wrapper. On start, takes the
//  array (test_mode=1) and runs the 6 march elements over every address. Each read is compared
//  against the expected background; first-failure info and a fail count are recorded.
//  Drives the wrapper's mbist_rd/mbist_wr/mbist_addr/mbist_din/test_mode; observes mem_dout.
// PARAMETERS
//  addr          4  address width; N = 2**addr words
//  data          8  data width; backgrounds are all-0 / all-1
//  STOP_ON_FAIL  0  1: end test right after first mismatch
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     begin test; sampled only in IDLE or DONE
//  mem_dout     in   data  memory read data, valid 1 cycle after mbist_rd
//  test_mode    out  1     wrapper select: 1 = MBIST owns memory
//  mbist_rd     out  1     read strobe
//  mbist_wr     out  1     write strobe
//  mbist_addr   out  addr  access address
//  mbist_din    out  data  write data
//  busy         out  1     test in progress
//  done         out  1     test finished; held until start or rst
//  fail         out  1     sticky: any mismatch this run
//  fail_addr    out  addr  address of first mismatch
//  fail_data    out  data  mem_dout at first mismatch
//  fail_cnt     out  8     mismatch count, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0 at next edge, state IDLE; from any state, incl. mid-test.
//  - Sequence: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 dn(r0).
//    up = addr 0..N-1, dn = N-1..0. One op per cycle; r/w pair at one address, then next address.
//  - Timing: start seen in IDLE/DONE -> cycle 1 = first op. Ops occupy cycles 1..10N.
//    Cycle 10N+1 = FLUSH (no strobe, last compare). Cycle 10N+2 = DONE.
//  - Each op cycle: exactly one of mbist_rd/mbist_wr = 1.
//    mbist_din = {data{bit}} on writes, 0 otherwise.
//  - test_mode = busy = 1 from cycle 1 through FLUSH; 0 in IDLE and DONE.
//  - Compare pipeline: a read registers chk_q=1 and exp_q. Next cycle: mismatch = chk_q && (mem_dout != exp_q).
//  - On mismatch: fail, fail_cnt++ (saturating) at the next edge. fail_addr/fail_data capture first mismatch only.
//  - STOP_ON_FAIL=1: no further op is issued after the mismatch cycle. Next cycle = DONE.
//  - start in DONE clears fail, fail_cnt, fail_addr, fail_data and done; restarts at cycle 1.
//  - start while busy is ignored. start held high in DONE restarts each completion.
//  - States: IDLE, M0..M5 (each with phase RD/WR), FLUSH, DONE.
//    Element ends at last address of the last phase -> next element, first address of its direction.
// STRUCTURE
//  - mbist_defs.vh: state encodings, element direction/op/background table, fail_cnt width.
//  - Sub-module mbist_addr_gen: loadable up/down counter; inputs clr, inc, dir; outputs addr, is_last.
//  - FSM, compare pipeline and fail capture stay in mbist_controller.
// TESTING (addr=4, data=8, N=16, fault-injecting memory model, 1-cycle read latency)
//  1. Fault-free: pulse start.
//     -> cycle 1 wr addr0 din 0x00; done=1 at cycle 162; fail=0, fail_cnt=0; test_mode 0 after.
//  2. Bit3 stuck-at-1 @ addr5.
//     -> fail=1, fail_addr=5, fail_data=0x08; fail_cnt=3 (M1, M3, M5 r0); done at 162.
//  3. STOP_ON_FAIL=1, same fault.
//     -> M1 read addr5 at cycle 27, compare 28, done=1 at cycle 29; no strobes after 27.
//  4. Order check.
//     -> M3 starts cycle 81 with rd addr15 (exp 0x00); M5 rd addr15 at 145 ... addr0 at 160.
//  5. rst at cycle 50.
//     -> cycle 51 all outputs 0; new start gives a full 162-cycle run, fault-free result.
//  6. start pulsed at cycles 10 and 100 (busy).
//     -> ignored, done still at 162; start in DONE clears fail flags and reruns.

Source files
------------

// File: rtl/mbist_controller_pkg.sv
// Shared encodings for the March C- engine: FSM states, op phases and the
// per-element direction / operation / background table.
package mbist_controller_pkg;

  localparam int FCNT_W = 8;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;

  typedef struct packed {
    logic up;
    logic has_rd;
    logic has_wr;
    logic rd_bg;
    logic wr_bg;
  } elem_t;

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 dn(r0)
  function automatic elem_t elem_info(input logic [2:0] e);
    case (e)
      3'd0:    elem_info = '{up: 1'b1, has_rd: 1'b0, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0};
      3'd1:    elem_info = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd2:    elem_info = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd3:    elem_info = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd4:    elem_info = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd5:    elem_info = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
      default: elem_info = '0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter. Direction is latched on clr so is_last
// depends only on registered state.
module mbist_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dir,
  output logic [AW-1:0] addr,
  output logic          is_last
);

  logic up_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      up_q <= 1'b1;
    end else if (clr) begin
      addr <= dir ? '0 : '1;
      up_q <= dir;
    end else if (inc) begin
      addr <= up_q ? AW'(addr + 1'b1) : AW'(addr - 1'b1);
    end
  end

  assign is_last = up_q ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/mbist_controller.sv
// March C- MBIST engine: walks six march elements over the array, compares
// reads one cycle later and records first-failure info plus a fail count.
module mbist_controller
  import mbist_controller_pkg::*;
#(
  parameter int addr         = 4,
  parameter int data         = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [data-1:0]   mem_dout,
  output logic              test_mode,
  output logic              mbist_rd,
  output logic              mbist_wr,
  output logic [addr-1:0]   mbist_addr,
  output logic [data-1:0]   mbist_din,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [addr-1:0]   fail_addr,
  output logic [data-1:0]   fail_data,
  output logic [FCNT_W-1:0] fail_cnt
);

  logic [3:0]      state_q, state_d;
  logic            ph_q, ph_d;
  logic [2:0]      e_idx, e_nxt;
  logic            in_op, start_ok, mismatch, halt, op_en, rd_op, wr_op;
  logic            ag_clr, ag_inc, ag_dir, ag_last;
  logic [addr-1:0] ag_addr, chk_addr_q;
  logic            chk_q;
  logic [data-1:0] exp_q;
  logic            last_ph;

  mbist_addr_gen #(.AW(addr)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (ag_clr),
    .inc     (ag_inc),
    .dir     (ag_dir),
    .addr    (ag_addr),
    .is_last (ag_last)
  );

  assign e_idx    = 3'(state_q - S_M0);
  assign e_nxt    = 3'(e_idx + 3'd1);
  assign in_op    = (state_q >= S_M0) && (state_q <= S_M5);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mismatch = chk_q && (mem_dout != exp_q);
  // Stop-on-fail suppresses the op in the very cycle the miscompare is seen.
  assign halt     = (STOP_ON_FAIL != 0) && mismatch;
  assign op_en    = in_op && !halt;
  assign rd_op    = op_en && (ph_q == PH_RD);
  assign wr_op    = op_en && (ph_q == PH_WR);
  assign last_ph  = elem_info(e_idx).has_wr ? PH_WR : PH_RD;

  assign mbist_rd   = rd_op;
  assign mbist_wr   = wr_op;
  assign mbist_addr = op_en ? ag_addr : '0;
  assign mbist_din  = wr_op ? {data{elem_info(e_idx).wr_bg}} : '0;
  assign busy       = in_op || (state_q == S_FLUSH);
  assign test_mode  = busy;
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    ag_clr  = 1'b0;
    ag_inc  = 1'b0;
    ag_dir  = 1'b1;
    if (start_ok) begin
      state_d = S_M0;
      ph_d    = PH_WR;
      ag_clr  = 1'b1;
    end else if (in_op) begin
      if (halt) begin
        state_d = S_DONE;
      end else if (ph_q != last_ph) begin
        ph_d = PH_WR;
      end else if (!ag_last) begin
        ag_inc = 1'b1;
        ph_d   = elem_info(e_idx).has_rd ? PH_RD : PH_WR;
      end else if (state_q == S_M5) begin
        state_d = S_FLUSH;
      end else begin
        state_d = 4'(state_q + 4'd1);
        ag_clr  = 1'b1;
        ag_dir  = elem_info(e_nxt).up;
        ph_d    = elem_info(e_nxt).has_rd ? PH_RD : PH_WR;
      end
    end else if (state_q == S_FLUSH) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ph_q       <= PH_WR;
      chk_q      <= 1'b0;
      exp_q      <= '0;
      chk_addr_q <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      chk_q      <= rd_op;
      exp_q      <= {data{elem_info(e_idx).rd_bg}};
      chk_addr_q <= ag_addr;
      if (start_ok) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_cnt  <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= chk_addr_q;
          fail_data <= mem_dout;
        end
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule
